// File: rtl/cell_fb_pkg.sv
// ---------------------------------------------------------------------------
// cell_fb_pkg
// Shared definitions for the 40x30 one-bit cell framebuffer: grid geometry,
// command opcodes, the write-side FSM state encoding, the packed command
// word stored in the command FIFO and the cell address helper. The pixel
// driver imports the grid constants from here as well.
// ---------------------------------------------------------------------------
package cell_fb_pkg;

   // Grid geometry, sized to the command fields so bounds compares are exact.
   localparam logic [5:0]  GRID_COLS   = 6'd40;
   localparam logic [4:0]  GRID_ROWS   = 5'd30;
   localparam logic [10:0] TOTAL_CELLS = 11'd1200;
   localparam logic [10:0] LAST_CELL   = TOTAL_CELLS - 11'd1;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_CLEAR = 2'd1,
      OP_FILL  = 2'd2,
      OP_NOP   = 2'd3   // reserved, discarded silently
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_SWEEP = 2'd2
   } state_t;

   // 14-bit command word held in the FIFO.
   typedef struct packed {
      cmd_op_t    op;
      logic [5:0] col;
      logic [4:0] row;
      logic       value;
   } cmd_t;

   // Row-major cell address, computed at 11 bits (max 1199, never wraps).
   function automatic logic [10:0] cell_addr(input logic [5:0] col,
                                             input logic [4:0] row);
      return ({6'd0, row} * {5'd0, GRID_COLS}) + {5'd0, col};
   endfunction

endpackage

// File: rtl/cell_fb_writer_if.sv
// ---------------------------------------------------------------------------
// cell_fb_writer_if
// Valid/ready cell command channel into cell_fb_writer.
//   cmd_valid  command present            (master -> slave)
//   cmd_ready  FIFO can accept            (slave  -> master)
//   cmd_op     0 WRITE, 1 CLEAR_ALL, 2 FILL_ALL, 3 reserved
//   cmd_col    target column, WRITE only
//   cmd_row    target row, WRITE only
//   cmd_value  cell value, WRITE only
// ---------------------------------------------------------------------------
interface cell_fb_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [5:0] cmd_col;
   logic [4:0] cmd_row;
   logic       cmd_value;

   modport master (output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_value,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, cmd_op, cmd_col, cmd_row, cmd_value,
                   output cmd_ready);
endinterface

// File: rtl/cell_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cell_cmd_fifo
// Synchronous FIFO for cell commands. The head entry is presented
// combinationally on pop_data, so a word pushed on edge N is visible from
// the cycle after N.
//   clk_74a    clock, rising edge
//   reset_n    asynchronous active-low reset (empties the FIFO)
//   push       write push_data (caller guarantees !full)
//   push_data  WIDTH-bit entry
//   pop        drop the head entry (caller guarantees !empty)
//   pop_data   head entry
//   full       no free entry
//   empty      no valid entry
// DEPTH must be a power of two, minimum 2.
// ---------------------------------------------------------------------------
module cell_cmd_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 8
) (
   input  logic             clk_74a,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit tells full apart from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // NOTE: the storage array is deliberately not reset; its contents are
   // only ever read behind the pointers, and leaving it unreset lets it map
   // onto plain RAM/LUT storage.
   always_ff @(posedge clk_74a) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cell_fb_writer.sv
// ---------------------------------------------------------------------------
// cell_fb_writer
// Write-side stage of the 40x30 one-bit cell framebuffer. Buffers cell
// commands in a FIFO and commits them to SRAM only during vertical
// blanking, so the pixel driver's display reads never see a write.
//   clk_74a       system clock, rising edge
//   reset_n       asynchronous active-low reset
//   in_vblank     vertical blanking, synchronous to clk_74a
//   cmd           command channel (cell_fb_writer_if.slave)
//   sram_addr     SRAM write address
//   sram_wr_en    one-cycle write strobe
//   sram_data_in  SRAM write data
//   sram_read_ok  low exactly on write cycles
//   busy          FIFO non-empty or FSM not idle
//   err_oob       one-cycle pulse when an out-of-bounds WRITE is dropped
// Optional (macro CELL_FB_STATS_EN):
//   oob_count     saturating count of err_oob pulses
//   sweep_count   wrapping count of completed CLEAR/FILL sweeps
// ---------------------------------------------------------------------------
module cell_fb_writer
   import cell_fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk_74a,
   input  logic                reset_n,
   input  logic                in_vblank,
   cell_fb_writer_if.slave     cmd,
   output logic [10:0]         sram_addr,
   output logic                sram_wr_en,
   output logic                sram_data_in,
   output logic                sram_read_ok,
   output logic                busy,
   output logic                err_oob
`ifdef CELL_FB_STATS_EN
   ,
   output logic [7:0]          oob_count,
   output logic [7:0]          sweep_count
`endif
);

   state_t            state, state_n;
   cmd_t              head;
   logic [$bits(cmd_t)-1:0] head_bits;
   logic              fifo_full, fifo_empty;
   logic              pop;
   logic [10:0]       addr_n;
   logic              data_n, wr_n, err_n, sweep_done;

   assign cmd.cmd_ready = ~fifo_full;

   cell_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_74a   (clk_74a),
      .reset_n   (reset_n),
      .push      (cmd.cmd_valid & ~fifo_full),
      .push_data ({cmd.cmd_op, cmd.cmd_col, cmd.cmd_row, cmd.cmd_value}),
      .pop       (pop),
      .pop_data  (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head = cmd_t'(head_bits);
   assign busy = ~fifo_empty | (state != ST_IDLE);

   // SRAM outputs are registered: the comb block computes the value each
   // output takes after the coming edge.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_n    = state;
      addr_n     = sram_addr;
      data_n     = sram_data_in;
      wr_n       = 1'b0;
      err_n      = 1'b0;
      pop        = 1'b0;
      sweep_done = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (in_vblank && !fifo_empty) begin
               pop = 1'b1;
               unique case (head.op)
                  OP_WRITE: begin
                     if (head.col < GRID_COLS && head.row < GRID_ROWS) begin
                        addr_n  = cell_addr(head.col, head.row);
                        data_n  = head.value;
                        state_n = ST_WRITE;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  OP_CLEAR, OP_FILL: begin
                     addr_n  = '0;
                     data_n  = (head.op == OP_FILL);
                     state_n = ST_SWEEP;
                  end
                  default: ;   // reserved op: discard
               endcase
            end
         end

         // A WRITE popped as vblank fell parks here until the next vblank.
         ST_WRITE: begin
            if (in_vblank) begin
               wr_n    = 1'b1;
               state_n = ST_IDLE;
            end
         end

         // sram_wr_en high means the current address is being written this
         // cycle, so the address only advances once that write is done; a
         // vblank gap then holds the next, not-yet-written address.
         ST_SWEEP: begin
            if (sram_wr_en) begin
               if (sram_addr == LAST_CELL) begin
                  state_n    = ST_IDLE;
                  sweep_done = 1'b1;
               end else begin
                  addr_n = sram_addr + 11'd1;
                  wr_n   = in_vblank;
               end
            end else begin
               wr_n = in_vblank;
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         sram_addr    <= '0;
         sram_data_in <= 1'b0;
         sram_wr_en   <= 1'b0;
         sram_read_ok <= 1'b1;
         err_oob      <= 1'b0;
      end else begin
         state        <= state_n;
         sram_addr    <= addr_n;
         sram_data_in <= data_n;
         sram_wr_en   <= wr_n;
         sram_read_ok <= ~wr_n;
         err_oob      <= err_n;
      end
   end

`ifdef CELL_FB_STATS_EN
   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         oob_count   <= '0;
         sweep_count <= '0;
      end else begin
         if (err_n && oob_count != 8'hFF) oob_count <= oob_count + 8'd1;
         if (sweep_done)                  sweep_count <= sweep_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cell_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_cell_fb_writer
// Self-checking bench for cell_fb_writer. The reference model works at the
// command level: each accepted command appends its expected SRAM writes to
// an ordered queue and updates a model image of the 1200 cells; a negedge
// monitor matches every observed write against that queue.
// ---------------------------------------------------------------------------
module tb_cell_fb_writer;

   logic        clk_74a = 1'b0;
   logic        reset_n;
   logic        in_vblank;
   logic [10:0] sram_addr;
   logic        sram_wr_en, sram_data_in, sram_read_ok, busy, err_oob;
`ifdef CELL_FB_STATS_EN
   logic [7:0]  oob_count, sweep_count;
`endif

   cell_fb_writer_if cmd_if ();

   cell_fb_writer #(.FIFO_DEPTH(8)) dut (
      .clk_74a      (clk_74a),
      .reset_n      (reset_n),
      .in_vblank    (in_vblank),
      .cmd          (cmd_if),
      .sram_addr    (sram_addr),
      .sram_wr_en   (sram_wr_en),
      .sram_data_in (sram_data_in),
      .sram_read_ok (sram_read_ok),
      .busy         (busy),
      .err_oob      (err_oob)
`ifdef CELL_FB_STATS_EN
      ,
      .oob_count    (oob_count),
      .sweep_count  (sweep_count)
`endif
   );

   always #5 clk_74a = ~clk_74a;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;

   typedef struct {
      int addr;
      bit data;
   } wr_t;

   int  tests = 0;
   int  fails = 0;
   wr_t exp_q[$];
   bit  mdl_img [CELLS];
   bit  obs_img [CELLS];
   int  exp_err    = 0;
   int  exp_sweeps = 0;
   int  err_count  = 0;
   int  wr_count   = 0;
   int  last_addr  = 0;
   int  wr_cyc     = 0;
   int  acc_cyc    = 0;
   int  cyc        = 0;
   logic vb_edge   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_74a) begin
      cyc     <= cyc + 1;
      vb_edge <= in_vblank;
   end

   // Write monitor: every strobe must be the next expected write and must
   // come from an edge that saw vblank high.
   always @(negedge clk_74a) begin
      if (reset_n) begin
         check("read_ok", {31'd0, sram_read_ok}, {31'd0, ~sram_wr_en});
         if (sram_wr_en) begin
            check("wr_in_vblank", {31'd0, vb_edge}, 32'd1);
            check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", {21'd0, sram_addr}, e.addr);
               check("wr_data", {31'd0, sram_data_in}, {31'd0, e.data});
            end
            if (int'(sram_addr) < CELLS) obs_img[sram_addr] = sram_data_in;
            wr_count++;
            last_addr = int'(sram_addr);
            wr_cyc    = cyc;
         end
         if (err_oob) err_count++;
      end
   end

   // Model: commands execute in acceptance order and sweeps run to the end.
   task automatic model_cmd(input logic [1:0] op, input int col, input int row,
                            input bit val);
      case (op)
         2'd0: begin
            if (col < COLS && row < ROWS) begin
               exp_q.push_back('{row * COLS + col, val});
               mdl_img[row * COLS + col] = val;
            end else begin
               exp_err++;
            end
         end
         2'd1, 2'd2: begin
            for (int i = 0; i < CELLS; i++) begin
               exp_q.push_back('{i, op == 2'd2});
               mdl_img[i] = (op == 2'd2);
            end
            exp_sweeps++;
         end
         default: ;
      endcase
   endtask

   task automatic push(input logic [1:0] op, input int col, input int row,
                       input bit val);
      int w;
      @(negedge clk_74a);
      w = 0;
      while (!cmd_if.cmd_ready && w < 200) begin
         in_vblank = 1'b1;
         @(negedge clk_74a);
         w++;
      end
      check("push_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      if (cmd_if.cmd_ready) begin
         cmd_if.cmd_op    = op;
         cmd_if.cmd_col   = 6'(col);
         cmd_if.cmd_row   = 5'(row);
         cmd_if.cmd_value = val;
         cmd_if.cmd_valid = 1'b1;
         acc_cyc = cyc + 1;
         model_cmd(op, col, row, val);
         @(posedge clk_74a);
         #1 cmd_if.cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag, input int max);
      int i;
      i = 0;
      do begin
         @(negedge clk_74a);
         #1 i++;
      end while ((busy || sram_wr_en) && i < max);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_pending"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"},   {31'd0, cmd_if.cmd_ready}, 32'd1);
      check({tag, "_addr"},    {21'd0, sram_addr},        32'd0);
      check({tag, "_wr_en"},   {31'd0, sram_wr_en},       32'd0);
      check({tag, "_data"},    {31'd0, sram_data_in},     32'd0);
      check({tag, "_read_ok"}, {31'd0, sram_read_ok},     32'd1);
      check({tag, "_busy"},    {31'd0, busy},             32'd0);
      check({tag, "_err"},     {31'd0, err_oob},          32'd0);
   endtask

   function automatic int img_diff();
      int n;
      n = 0;
      for (int i = 0; i < CELLS; i++) if (mdl_img[i] != obs_img[i]) n++;
      return n;
   endfunction

   initial begin
      int base, base_err, i, c, r, k;

      reset_n          = 1'b0;
      in_vblank        = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'd0;
      cmd_if.cmd_col   = '0;
      cmd_if.cmd_row   = '0;
      cmd_if.cmd_value = 1'b0;
      repeat (3) @(negedge clk_74a);
      #1 check_reset_vals("reset");
      reset_n = 1'b1;

      // 1: single in-bounds WRITE, latency from accept to strobe
      in_vblank = 1'b1;
      base = wr_count;
      push(2'd0, 3, 2, 1'b1);
      i = 0;
      while (wr_count == base && i < 20) begin
         @(negedge clk_74a);
         #1 i++;
      end
      check("t1_latency", wr_cyc - acc_cyc, 32'd2);
      repeat (5) @(negedge clk_74a);
      #1 check("t1_writes", wr_count - base, 32'd1);
      check("t1_addr", last_addr, 2 * COLS + 3);

      // 2: eight WRITEs buffered outside vblank, then drained in order
      in_vblank = 1'b0;
      base = wr_count;
      for (int n = 0; n < 8; n++)
         push(2'd0, $urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1),
              1'($urandom_range(0, 1)));
      @(negedge clk_74a);
      #1 check("t2_full_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      check("t2_full_busy", {31'd0, busy}, 32'd1);
      repeat (10) @(negedge clk_74a);
      #1 check("t2_no_write", wr_count - base, 32'd0);
      in_vblank = 1'b1;
      wait_idle("t2_drain", 100);
      check("t2_writes", wr_count - base, 32'd8);
      check("t2_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

      // 3: out-of-bounds WRITE is dropped with one err_oob pulse
      base = wr_count;
      base_err = err_count;
      push(2'd0, COLS, 0, 1'b1);
      repeat (5) @(negedge clk_74a);
      #1 check("t3_err_pulses", err_count - base_err, 32'd1);
      check("t3_no_write", wr_count - base, 32'd0);
`ifdef CELL_FB_STATS_EN
      check("t3_oob_count", {24'd0, oob_count}, exp_err);
`endif

      // Random command mix with vblank toggling between commands
      for (int n = 0; n < 40; n++) begin
         in_vblank = ($urandom_range(0, 3) != 0);
         k = $urandom_range(0, 9);
         c = $urandom_range(0, 45);
         r = $urandom_range(0, 31);
         push((k >= 8) ? 2'd3 : 2'd0, c, r, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk_74a);
      end
      in_vblank = 1'b1;
      wait_idle("rnd_drain", 200);
      check("rnd_err_count", err_count, exp_err);
      check("rnd_image", img_diff(), 32'd0);

      // 4: FILL_ALL with vblank held high
      base = wr_count;
      push(2'd2, 0, 0, 1'b0);
      repeat (1300) @(negedge clk_74a);
      #1 check("t4_writes", wr_count - base, CELLS);
      check("t4_last_addr", last_addr, CELLS - 1);
      check("t4_busy", {31'd0, busy}, 32'd0);
      check("t4_image", img_diff(), 32'd0);
`ifdef CELL_FB_STATS_EN
      check("t4_sweep_count", {24'd0, sweep_count}, exp_sweeps % 256);
`endif

      // 5: CLEAR_ALL interrupted by active video after 500 writes
      base = wr_count;
      push(2'd1, 0, 0, 1'b0);
      i = 0;
      while (wr_count - base < 500 && i < 1300) begin
         @(negedge clk_74a);
         #1 i++;
      end
      in_vblank = 1'b0;
      repeat (20) @(negedge clk_74a);
      #1 check("t5_paused_writes", wr_count - base, 32'd500);
      check("t5_held_addr", {21'd0, sram_addr}, 32'd500);
      check("t5_paused_wr_en", {31'd0, sram_wr_en}, 32'd0);
      check("t5_paused_busy", {31'd0, busy}, 32'd1);
      in_vblank = 1'b1;
      wait_idle("t5_resume", 1300);
      check("t5_writes", wr_count - base, CELLS);
      check("t5_last_addr", last_addr, CELLS - 1);
      check("t5_image", img_diff(), 32'd0);

      // 6: reset in the middle of a sweep
      base = wr_count;
      push(2'd2, 0, 0, 1'b0);
      i = 0;
      while (!(wr_count > base && last_addr == 700) && i < 1300) begin
         @(negedge clk_74a);
         #1 i++;
      end
      check("t6_reached_700", last_addr, 32'd700);
      reset_n = 1'b0;
      #1 check_reset_vals("t6_reset");
      exp_q.delete();
      exp_err    = 0;
      exp_sweeps = 0;
`ifdef CELL_FB_STATS_EN
      check("t6_oob_count", {24'd0, oob_count}, exp_err);
      check("t6_sweep_count", {24'd0, sweep_count}, exp_sweeps);
`endif
      repeat (3) @(negedge clk_74a);
      reset_n = 1'b1;
      base = wr_count;
      repeat (50) @(negedge clk_74a);
      #1 check("t6_no_write", wr_count - base, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
